// File: rtl/regfile_pkg.sv
// Shared constants and write-port merge helper for the multi-port register file.
// Latency: n/a (package). Backpressure: n/a.
// Contents: default sizes, the hard-wired zero index, and the per-register write-selection function.
package regfile_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_DEPTH  = 32;
   localparam int ZERO_IDX  = 0;

   // Per-register write decision: en = some port writes this register this edge,
   // from_b = port B supplies the data (B wins a same-address collision).
   typedef struct packed {
      logic en;
      logic from_b;
   } wr_pick_t;

   // True when an enabled write port targets register idx, honouring the hard-wired zero register.
   function automatic logic wr_hit(
      input int unsigned idx,
      input logic        zero_reg,
      input logic        wa_en,
      input int unsigned wa_addr,
      input logic        wb_en,
      input int unsigned wb_addr
   );
      logic hit;
      hit = (wa_en && (wa_addr == idx)) || (wb_en && (wb_addr == idx));
      if (zero_reg && (idx == ZERO_IDX))
         hit = 1'b0;
      return hit;
   endfunction

   // Merge the two write ports into a next-value select for one register.
   function automatic wr_pick_t wr_merge(
      input int unsigned idx,
      input logic        zero_reg,
      input logic        wa_en,
      input int unsigned wa_addr,
      input logic        wb_en,
      input int unsigned wb_addr
   );
      wr_pick_t pick;
      pick.en     = wr_hit(idx, zero_reg, wa_en, wa_addr, wb_en, wb_addr);
      pick.from_b = wb_en && (wb_addr == idx);
      return pick;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-producer bit per architectural register.
// Latency: set and clear both take effect on the next rising edge.
// Backpressure: none; the hazard unit reads the busy vector and stalls issue itself.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears every busy bit)
//   iss_en, iss_addr    issue of an instruction whose destination becomes busy
//   wa_*/wb_*           write ports; a write retires the pending producer
//   busy                full busy vector, one bit per register
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DEPTH    = RF_DEPTH,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic              wa_en,
   input  logic [ADDR_W-1:0] wa_addr,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   output logic [DEPTH-1:0]  busy
);

   genvar r;
   generate
      for (r = 0; r < DEPTH; r++) begin : g_busy
         if ((ZERO_REG != 0) && (r == ZERO_IDX)) begin : g_zero
            // The zero register never has a pending producer.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)
                  busy[r] <= 1'b0;
               else
                  busy[r] <= 1'b0;
            end
         end else begin : g_live
            logic iss_hit;
            logic wr_clr;

            always_comb begin
               iss_hit = iss_en && (iss_addr == ADDR_W'(r));
               wr_clr  = wr_hit(32'(r), ZERO_REG != 0, wa_en, 32'(wa_addr),
                                wb_en, 32'(wb_addr));
            end

            // Issue beats write: a same-edge write retires the older producer,
            // while the newly issued one is still outstanding.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n)
                  busy[r] <= 1'b0;
               else if (iss_hit)
                  busy[r] <= 1'b1;
               else if (wr_clr)
                  busy[r] <= 1'b0;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass, two write ports and a busy scoreboard.
// Latency: reads combinational (0 cycles); writes, busy updates and last_wr land on the next edge.
// Backpressure: none; enables are single-cycle qualifiers and every enabled cycle is a transaction.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears storage, busy bits, last_wr)
//   rd_addr/rd_data     NUM_RD packed read ports, port k at [k*W +: W]
//   rd_busy             busy bit per read port, masked when a same-cycle write supplies the value
//   wa_*                write port A (writeback)
//   wb_*                write port B (late result / load return), wins address collisions
//   iss_en/iss_addr     mark the destination of an issuing instruction busy
//   last_wr             data of the most recent committed write (B over A when both fire)
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int DEPTH    = RF_DEPTH,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wa_en,
   input  logic [ADDR_W-1:0]        wa_addr,
   input  logic [DATA_W-1:0]        wa_data,
   input  logic                     wb_en,
   input  logic [ADDR_W-1:0]        wb_addr,
   input  logic [DATA_W-1:0]        wb_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   output logic [DATA_W-1:0]        last_wr
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy_vec;

   // ------------------------------------------------------------------
   // Storage: one flop row per register, write select from the shared merge.
   // With ZERO_REG the merge never enables row 0, so it stays at its reset 0.
   // ------------------------------------------------------------------
   genvar r;
   generate
      for (r = 0; r < DEPTH; r++) begin : g_reg
         wr_pick_t pick;

         always_comb begin
            pick = wr_merge(32'(r), ZERO_REG != 0, wa_en, 32'(wa_addr),
                            wb_en, 32'(wb_addr));
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               mem[r] <= '0;
            else if (pick.en)
               mem[r] <= pick.from_b ? wb_data : wa_data;
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Observation register: writes to index 0 still count as committed here.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_wr <= '0;
      else if (wb_en)
         last_wr <= wb_data;
      else if (wa_en)
         last_wr <= wa_data;
   end

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   regfile_scoreboard #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .wa_en    (wa_en),
      .wa_addr  (wa_addr),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .busy     (busy_vec)
   );

   // ------------------------------------------------------------------
   // Read ports: zero register, then port B, then port A, then storage.
   // ------------------------------------------------------------------
   genvar k;
   generate
      for (k = 0; k < NUM_RD; k++) begin : g_rd
         logic [ADDR_W-1:0] addr;
         logic              a_hit;
         logic              b_hit;
         logic              is_zero;
         logic [DATA_W-1:0] data;

         assign addr = rd_addr[k*ADDR_W +: ADDR_W];

         always_comb begin
            a_hit   = wa_en && (wa_addr == addr);
            b_hit   = wb_en && (wb_addr == addr);
            is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_IDX));
            if (is_zero)
               data = '0;
            else if (b_hit)
               data = wb_data;
            else if (a_hit)
               data = wa_data;
            else
               data = mem[addr];
         end

         assign rd_data[k*DATA_W +: DATA_W] = data;
         // A same-cycle write already supplies the value through the bypass,
         // so the consumer need not stall on it.
         assign rd_busy[k] = busy_vec[addr] & ~(a_hit | b_hit);
      end
   endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Per-instance stimulus: index 0 = default config, index 1 = DEPTH16/NUM_RD3/no zero reg.
   logic        wa_en_s   [2];
   logic        wb_en_s   [2];
   logic        iss_en_s  [2];
   logic [4:0]  wa_addr_s [2];
   logic [4:0]  wb_addr_s [2];
   logic [4:0]  iss_addr_s[2];
   logic [31:0] wa_data_s [2];
   logic [31:0] wb_data_s [2];

   logic [9:0]  rd_addr0;
   logic [11:0] rd_addr1;
   logic [63:0] rd_data0;
   logic [95:0] rd_data1;
   logic [1:0]  rd_busy0;
   logic [2:0]  rd_busy1;
   logic [31:0] last0, last1;

   int  vec  = 0;
   int  errs = 0;
   bit  run  = 1'b0;
   bit  dut1_rand = 1'b1;

   regfile_mp #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .rd_addr(rd_addr0), .rd_data(rd_data0), .rd_busy(rd_busy0),
      .wa_en(wa_en_s[0]), .wa_addr(wa_addr_s[0]), .wa_data(wa_data_s[0]),
      .wb_en(wb_en_s[0]), .wb_addr(wb_addr_s[0]), .wb_data(wb_data_s[0]),
      .iss_en(iss_en_s[0]), .iss_addr(iss_addr_s[0]), .last_wr(last0)
   );

   regfile_mp #(.DATA_W(32), .DEPTH(16), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_busy(rd_busy1),
      .wa_en(wa_en_s[1]), .wa_addr(wa_addr_s[1][3:0]), .wa_data(wa_data_s[1]),
      .wb_en(wb_en_s[1]), .wb_addr(wb_addr_s[1][3:0]), .wb_data(wb_data_s[1]),
      .iss_en(iss_en_s[1]), .iss_addr(iss_addr_s[1][3:0]), .last_wr(last1)
   );

   // ---------------- reference model ----------------
   logic [31:0] mm [2][32];
   bit          bm [2][32];
   logic [31:0] lm [2];
   bit          zr [2] = '{1'b1, 1'b0};

   // Writes applied in order A then B so B wins; busy cleared by writes, then set by issue.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            lm[i] <= '0;
            for (int j = 0; j < 32; j++) begin
               mm[i][j] <= '0;
               bm[i][j] <= 1'b0;
            end
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (wa_en_s[i] && !(zr[i] && wa_addr_s[i] == 5'd0)) mm[i][wa_addr_s[i]] <= wa_data_s[i];
            if (wb_en_s[i] && !(zr[i] && wb_addr_s[i] == 5'd0)) mm[i][wb_addr_s[i]] <= wb_data_s[i];
            if (wa_en_s[i]) bm[i][wa_addr_s[i]] <= 1'b0;
            if (wb_en_s[i]) bm[i][wb_addr_s[i]] <= 1'b0;
            if (iss_en_s[i] && !(zr[i] && iss_addr_s[i] == 5'd0)) bm[i][iss_addr_s[i]] <= 1'b1;
            if (wb_en_s[i])      lm[i] <= wb_data_s[i];
            else if (wa_en_s[i]) lm[i] <= wa_data_s[i];
         end
      end
   end

   function automatic logic [31:0] exp_rd(input int i, input logic [4:0] a);
      if (zr[i] && a == 5'd0)                 return 32'd0;
      if (wb_en_s[i] && wb_addr_s[i] == a)    return wb_data_s[i];
      if (wa_en_s[i] && wa_addr_s[i] == a)    return wa_data_s[i];
      return mm[i][a];
   endfunction

   function automatic logic [31:0] exp_busy(input int i, input logic [4:0] a);
      if ((wa_en_s[i] && wa_addr_s[i] == a) || (wb_en_s[i] && wb_addr_s[i] == a)) return 32'd0;
      return {31'd0, bm[i][a]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         if (errs < 40) $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Per-cycle compare of every output of both instances against the model.
   always @(negedge clk) begin
      if (run) begin
         for (int k = 0; k < 2; k++) begin
            chk("d0_rd_data", rd_data0[k*32 +: 32], exp_rd(0, rd_addr0[k*5 +: 5]));
            chk("d0_rd_busy", 32'(rd_busy0[k]), exp_busy(0, rd_addr0[k*5 +: 5]));
         end
         for (int k = 0; k < 3; k++) begin
            chk("d1_rd_data", rd_data1[k*32 +: 32], exp_rd(1, {1'b0, rd_addr1[k*4 +: 4]}));
            chk("d1_rd_busy", 32'(rd_busy1[k]), exp_busy(1, {1'b0, rd_addr1[k*4 +: 4]}));
         end
         chk("d0_last_wr", last0, lm[0]);
         chk("d1_last_wr", last1, lm[1]);
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [4:0] rnd_addr(input int i);
      if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
      return 5'($urandom_range(0, (i == 0) ? 31 : 15));
   endfunction

   task automatic idle(input int i);
      wa_en_s[i] = 1'b0; wb_en_s[i] = 1'b0; iss_en_s[i] = 1'b0;
      wa_addr_s[i] = '0; wb_addr_s[i] = '0; iss_addr_s[i] = '0;
      wa_data_s[i] = '0; wb_data_s[i] = '0;
   endtask

   task automatic rand_inputs(input int i);
      wa_en_s[i]    = 1'($urandom_range(0, 1));
      wb_en_s[i]    = 1'($urandom_range(0, 1));
      iss_en_s[i]   = 1'($urandom_range(0, 1));
      wa_addr_s[i]  = rnd_addr(i);
      wb_addr_s[i]  = rnd_addr(i);
      iss_addr_s[i] = rnd_addr(i);
      wa_data_s[i]  = $urandom;
      wb_data_s[i]  = $urandom;
      if (i == 0) begin
         for (int k = 0; k < 2; k++) rd_addr0[k*5 +: 5] = rnd_addr(0);
      end else begin
         for (int k = 0; k < 3; k++) rd_addr1[k*4 +: 4] = 4'(rnd_addr(1));
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Instance 1 runs random traffic in the background.
   initial begin
      idle(1);
      rd_addr1 = '0;
      forever begin
         @(posedge clk);
         #1;
         if (dut1_rand) rand_inputs(1);
      end
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      rst_n = 1'b0;
      idle(0);
      rd_addr0 = '0;
      run = 1'b1;
      repeat (2) tick;
      rst_n = 1'b1;
      rd_addr0 = {5'd0, 5'd5};
      #3 chk("reset_rd_x5", rd_data0[31:0], 32'h0);
      chk("reset_last", last0, 32'h0);

      // Bypass
      tick; idle(0);
      rd_addr0 = {5'd0, 5'd3};
      wa_en_s[0] = 1'b1; wa_addr_s[0] = 5'd3; wa_data_s[0] = 32'h12345678;
      #3 chk("bypass_same", rd_data0[31:0], 32'h12345678);
      tick; idle(0);
      #3 chk("bypass_after", rd_data0[31:0], 32'h12345678);
      chk("bypass_last", last0, 32'h12345678);

      // Collision
      tick; idle(0);
      rd_addr0 = {5'd9, 5'd9};
      wa_en_s[0] = 1'b1; wa_addr_s[0] = 5'd9; wa_data_s[0] = 32'h1111;
      wb_en_s[0] = 1'b1; wb_addr_s[0] = 5'd9; wb_data_s[0] = 32'h2222;
      #3 chk("coll_same", rd_data0[63:32], 32'h2222);
      tick; idle(0);
      #3 chk("coll_after", rd_data0[63:32], 32'h2222);
      chk("coll_last", last0, 32'h2222);

      // Zero register
      tick; idle(0);
      rd_addr0 = {5'd0, 5'd0};
      wa_en_s[0] = 1'b1; wa_addr_s[0] = 5'd0; wa_data_s[0] = 32'hFFFFFFFF;
      wb_en_s[0] = 1'b1; wb_addr_s[0] = 5'd0; wb_data_s[0] = 32'hFFFFFFFF;
      iss_en_s[0] = 1'b1; iss_addr_s[0] = 5'd0;
      #3 chk("zero_rd_same", rd_data0[31:0], 32'h0);
      chk("zero_busy_same", 32'(rd_busy0[0]), 32'h0);
      tick; idle(0);
      #3 chk("zero_rd_after", rd_data0[31:0], 32'h0);
      chk("zero_busy_after", 32'(rd_busy0[0]), 32'h0);
      chk("zero_last", last0, 32'hFFFFFFFF);

      // Scoreboard race
      tick; idle(0);
      rd_addr0 = {5'd0, 5'd4};
      iss_en_s[0] = 1'b1; iss_addr_s[0] = 5'd4;
      #3 chk("race_busy_issue_cycle", 32'(rd_busy0[0]), 32'h0);
      tick; idle(0);
      #3 chk("race_busy_set", 32'(rd_busy0[0]), 32'h1);
      tick; idle(0);
      wa_en_s[0] = 1'b1; wa_addr_s[0] = 5'd4; wa_data_s[0] = 32'h44;
      iss_en_s[0] = 1'b1; iss_addr_s[0] = 5'd4;
      #3 chk("race_busy_masked", 32'(rd_busy0[0]), 32'h0);
      tick; idle(0);
      #3 chk("race_busy_reissued", 32'(rd_busy0[0]), 32'h1);
      tick; idle(0);
      wa_en_s[0] = 1'b1; wa_addr_s[0] = 5'd4; wa_data_s[0] = 32'h45;
      #3 chk("race_busy_wr_mask", 32'(rd_busy0[0]), 32'h0);
      tick; idle(0);
      #3 chk("race_busy_cleared", 32'(rd_busy0[0]), 32'h0);

      // Reset mid-operation
      tick; idle(0);
      wa_en_s[0] = 1'b1; wa_addr_s[0] = 5'd5; wa_data_s[0] = 32'hDEADBEEF;
      iss_en_s[0] = 1'b1; iss_addr_s[0] = 5'd7;
      tick; idle(0);
      rd_addr0 = {5'd7, 5'd5};
      #3 chk("pre_reset_x5", rd_data0[31:0], 32'hDEADBEEF);
      chk("pre_reset_busy7", 32'(rd_busy0[1]), 32'h1);
      tick; rst_n = 1'b0;
      #3 chk("in_reset_x5", rd_data0[31:0], 32'h0);
      chk("in_reset_busy7", 32'(rd_busy0[1]), 32'h0);
      tick;
      wa_en_s[0] = 1'b1; wa_addr_s[0] = 5'd5; wa_data_s[0] = 32'h55;
      tick; idle(0);
      rst_n = 1'b1;
      #3 chk("post_reset_x5", rd_data0[31:0], 32'h0);
      chk("post_reset_busy7", 32'(rd_busy0[1]), 32'h0);
      chk("post_reset_last", last0, 32'h0);

      // Random traffic, with one reset pulse in the middle
      for (int n = 0; n < 10000; n++) begin
         tick;
         rand_inputs(0);
         if (n == 5000) rst_n = 1'b0;
         if (n == 5002) rst_n = 1'b1;
      end

      // x0 is an ordinary register without the zero option
      #3 dut1_rand = 1'b0;
      tick; idle(0); idle(1);
      rd_addr1 = '0;
      wa_en_s[1] = 1'b1; wa_addr_s[1] = 5'd0; wa_data_s[1] = 32'hA5A5A5A5;
      #3 chk("d1_x0_same", rd_data1[31:0], 32'hA5A5A5A5);
      tick; idle(1);
      #3 chk("d1_x0_stored", rd_data1[31:0], 32'hA5A5A5A5);
      chk("d1_x0_last", last1, 32'hA5A5A5A5);

      tick;
      run = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
